// File: rtl/fetch_buffer.sv
// Instruction fetch stage: PC generation, req/gnt memory requests, prefetch FIFO
// and a valid/ready instruction stream toward decode, with redirect flush.
module fetch_buffer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              priv_in,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [28:0]       out_instr,
  output logic [2:0]        out_pred,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_priv
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  drop;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  tag_rd;
  logic [PTR_W-1:0]  tag_wr;

  // Prefetch FIFO storage
  logic [31:0]       word_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic              priv_mem [DEPTH];

  // Per-request tags, written at grant and consumed in order by responses
  logic [ADDR_W-1:0] tag_pc   [DEPTH];
  logic              tag_priv [DEPTH];

  logic             grant;
  logic             rsp;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] occupancy;

  // Issue uses only registered counts, so out_ready never reaches mem_req
  always_comb begin
    occupancy = SUM_W'(count) + SUM_W'(inflight);
    mem_req   = !rst && !halt && !redirect && (occupancy < SUM_W'(DEPTH));
    mem_addr  = fetch_pc;
    grant     = mem_req && mem_gnt;
    rsp       = mem_rvalid && (inflight != '0);
    push      = rsp && !redirect && (drop == '0);
    out_valid = (count != '0);
    pop       = out_valid && out_ready && !redirect;
  end

  always_comb begin
    out_instr = '0;
    out_pred  = '0;
    out_pc    = '0;
    out_priv  = 1'b0;
    if (out_valid) begin
      out_instr = word_mem[head][28:0];
      out_pred  = word_mem[head][31:29];
      out_pc    = pc_mem[head];
      out_priv  = priv_mem[head];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      head     <= '0;
      tail     <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        tag_wr   <= tag_wr + PTR_W'(1);
      end
      if (rsp) tag_rd <= tag_rd + PTR_W'(1);

      if (grant && !rsp)      inflight <= inflight + CNT_W'(1);
      else if (!grant && rsp) inflight <= inflight - CNT_W'(1);

      if (redirect) begin
        // Everything still outstanding after this cycle belongs to the old stream
        fetch_pc <= redirect_pc & ALIGN_MASK;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        drop     <= inflight + CNT_W'(grant) - CNT_W'(rsp);
      end else begin
        if (rsp && (drop != '0)) drop <= drop - CNT_W'(1);
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Data-path storage needs no reset; visibility is gated by count
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_pc[tag_wr]   <= fetch_pc;
      tag_priv[tag_wr] <= priv_in;
    end
    if (push) begin
      word_mem[tail] <= mem_rdata;
      pc_mem[tail]   <= tag_pc[tag_rd];
      priv_mem[tail] <= tag_priv[tag_rd];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized scoreboard bench for fetch_buffer: a memory responder, a
// transaction-level reference model and an output monitor.
module tb_fetch_buffer;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        priv_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_instr;
  logic [2:0]  out_pred;
  logic [31:0] out_pc;
  logic        out_priv;

  always #5 clk = ~clk;

  fetch_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .halt(halt), .priv_in(priv_in),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pred(out_pred), .out_pc(out_pc), .out_priv(out_priv)
  );

  typedef struct { logic [31:0] word; logic [31:0] pc; logic priv; } exp_t;
  typedef struct { logic [31:0] pc; logic priv; int unsigned epoch; } req_t;
  typedef struct { int unsigned due; logic [31:0] data; } mem_t;

  exp_t exp_q[$];   // instructions decode should see, in order
  req_t m_pend[$];  // granted requests not yet answered
  mem_t mem_q[$];   // memory responder's pending responses

  logic [31:0] exp_pc;
  int unsigned epoch;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  bit          first_word = 1'b1;

  int unsigned p_gnt, p_ready, p_halt, p_redir, p_spur, lat_min, lat_max, redir_jit;
  logic [31:0] redir_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against the reference model every cycle
  always @(negedge clk) begin
    if (rst) begin
      check("rst_mem_req", 64'(mem_req), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_instr", 64'(out_instr), 64'(0));
      check("rst_out_pred", 64'(out_pred), 64'(0));
      check("rst_out_pc", 64'(out_pc), 64'(0));
      check("rst_out_priv", 64'(out_priv), 64'(0));
    end else begin
      logic exp_req;
      exp_req = !halt && !redirect && ((exp_q.size() + m_pend.size()) < int'(DEPTH));
      check("mem_req", 64'(mem_req), 64'(exp_req));
      if (exp_req) check("mem_addr", 64'(mem_addr), 64'(exp_pc));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("out_instr", 64'(out_instr), 64'(exp_q[0].word[28:0]));
        check("out_pred", 64'(out_pred), 64'(exp_q[0].word[31:29]));
        check("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        check("out_priv", 64'(out_priv), 64'(exp_q[0].priv));
      end
    end
  end

  // Reference model: a redirect invalidates every older request via an epoch
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      m_pend.delete();
      exp_pc = RESET_PC;
      epoch  = 0;
    end else begin
      bit   g, r;
      req_t rq;
      r = mem_rvalid && (m_pend.size() != 0);
      g = !halt && !redirect && ((exp_q.size() + m_pend.size()) < int'(DEPTH)) && mem_gnt;
      if (redirect) begin
        exp_q.delete();
        epoch++;
        if (r) void'(m_pend.pop_front());
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (r) begin
          rq = m_pend.pop_front();
          if (rq.epoch == epoch) exp_q.push_back('{mem_rdata, rq.pc, rq.priv});
        end
        if (g) begin
          m_pend.push_back('{exp_pc, priv_in, epoch});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  // One cycle per iteration: drive at posedge+1, observe the bus at negedge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit          from_q;
      int unsigned due;
      from_q      = 1'b0;
      mem_gnt     = ($urandom_range(99) < p_gnt);
      out_ready   = ($urandom_range(99) < p_ready);
      halt        = ($urandom_range(99) < p_halt);
      redirect    = ($urandom_range(99) < p_redir);
      redirect_pc = redir_base ^ 32'($urandom_range(redir_jit));
      priv_in     = 1'($urandom_range(1));
      mem_rdata   = $urandom;
      mem_rvalid  = 1'b0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_q[0].data;
        from_q     = 1'b1;
      end else if (mem_q.size() == 0 && $urandom_range(99) < p_spur) begin
        mem_rvalid = 1'b1;
      end
      @(negedge clk);
      if (from_q) void'(mem_q.pop_front());
      if (mem_req && mem_gnt) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{due, first_word ? 32'hE000_0ABC : $urandom});
        first_word = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    p_redir = 100; redir_base = pc; redir_jit = 0;
    run(1);
    p_redir = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0; halt = 1'b0; out_ready = 1'b0;
    mem_q.delete();
    last_due = cyc;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; priv_in = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    p_gnt = 100; p_ready = 100; p_halt = 0; p_redir = 0; p_spur = 0;
    lat_min = 1; lat_max = 1; redir_base = '0; redir_jit = 0;
    do_reset();

    // Streaming from RESET_PC with a 1-cycle memory
    run(30);
    // Decode stalled: FIFO fills, requests stop; then single pops
    p_ready = 0; run(12);
    p_ready = 100; run(1);
    p_ready = 0; run(6);
    p_ready = 100; run(10);

    // 3-cycle memory, then redirect with three responses outstanding
    lat_min = 3; lat_max = 3; run(15);
    redirect_to(32'h2003);
    run(20);

    // Random redirects, often coincident with responses
    lat_min = 1; lat_max = 4; p_gnt = 70; p_ready = 60;
    p_redir = 10; redir_base = 32'h3000; redir_jit = 15;
    run(300);
    p_redir = 0;

    // Halt with two requests in flight at fetch_pc 0x10, then resume
    lat_min = 2; lat_max = 2; p_gnt = 100; p_ready = 100;
    redirect_to(32'h8);
    run(2);
    p_halt = 100; run(6);
    p_halt = 0; run(10);

    // PC wrap past the top of the address space
    lat_min = 1; lat_max = 1;
    redirect_to(32'hFFFF_FFF4);
    run(12);

    // Spurious responses with nothing in flight must be ignored
    p_spur = 30; lat_min = 1; lat_max = 5; p_gnt = 60; p_ready = 70;
    run(200);
    p_spur = 0;

    // Everything random, including halt and redirect
    p_halt = 20; p_redir = 5; p_ready = 50; redir_base = 32'h4000_0000; redir_jit = 255;
    run(400);

    // Asynchronous reset mid-stream, then recover
    do_reset();
    p_halt = 0; p_redir = 0; p_gnt = 80; p_ready = 80; lat_min = 1; lat_max = 3;
    run(50);

    // Drain
    p_gnt = 0; p_ready = 100;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Instruction fetch stage that sits directly upstream of the decoder. It keeps the program counter and issues word requests to instruction memory over a req/gnt handshake. Returned words go into a small prefetch FIFO. The stage presents one instruction at a time (29-bit body, 3-bit predicate field, PC, privilege bit) to decode over a valid/ready handshake. Redirects from execute flush the FIFO and discard in-flight responses.

Parameters:
ADDR_W, 32, width of PC and memory address (bytes)
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
halt  in  1  when 1, no new memory requests are issued; FIFO still drains
priv_in  in  1  current privilege level, sampled at each request grant
redirect  in  1  pulse: restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new PC; low 2 bits ignored (forced 0)
mem_req  out  1  request valid
mem_addr  out  ADDR_W  word-aligned request address
mem_gnt  in  1  request accepted this cycle (mem_req & mem_gnt)
mem_rvalid  in  1  response data valid; in order, at most 1 per cycle, >=1 cycle after its grant
mem_rdata  in  32  response word
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts (out_valid & out_ready = pop)
out_instr  out  29  mem word bits [28:0]
out_pred  out  3  mem word bits [31:29]
out_pc  out  ADDR_W  byte address of the presented instruction
out_priv  out  1  priv_in captured at that instruction's grant

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC; FIFO empty; inflight=0; drop=0; mem_req=0; out_valid=0; out_instr/out_pred/out_pc/out_priv=0.
- Request issue: mem_req = !halt & !redirect & (fifo_count + inflight < DEPTH). mem_addr = fetch_pc. The interface is purely combinational from the registered state plus halt/redirect.
- On grant: fetch_pc += 4, wrapping modulo 2^ADDR_W. Push {fetch_pc, priv_in} into a side queue of DEPTH entries so the tag travels with the request. inflight += 1.
- On mem_rvalid: inflight -= 1.
  - If drop > 0: drop -= 1 and discard the word.
  - Else: write {rdata, tag} into the FIFO. Space is guaranteed by the issue rule, so the FIFO never overflows.
- Grant and response in the same cycle: inflight unchanged.
- Output: out_valid = FIFO not empty. out_* are driven from the FIFO head; registered storage with combinational read of the head is allowed. Push and pop in the same cycle are both allowed at any occupancy, including full with a simultaneous pop.
- Redirect (highest priority):
  - In the redirect cycle: FIFO flushed (count=0, head/tail reset); fetch_pc <= redirect_pc & ~3.
  - drop <= inflight, adjusted for that cycle's events: +1 if a grant occurs, -1 if a response arrives. No grant can occur because mem_req=0 during redirect.
  - Any response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is not counted; decode must treat the output as squashed.
  - out_valid=0 the cycle after redirect.
- Halt: only blocks new requests. Outstanding responses still return and are buffered. Deasserting halt resumes at the current fetch_pc.
- Counter widths: inflight and drop are clog2(DEPTH)+1 bits; neither may overflow or underflow. A response arriving with inflight=0 is a protocol error and is ignored.
- First-valid latency after reset with a 1-cycle memory: req in cycle 0 (first cycle after reset release), rvalid in cycle 1, out_valid in cycle 2.
- No combinational path from out_ready to mem_req (issue uses the registered count).

Test Plan:
- Reset RESET_PC=0x100, 1-cycle memory, out_ready=1 -> addresses 0x100,0x104,0x108…; out_pc follows in order; out_instr=rdata[28:0], out_pred=rdata[31:29] for rdata=0xE000_0ABC (pred=7, instr=0x0000ABC).
- out_ready=0 with continuous grants -> exactly DEPTH(4) requests issued, then mem_req=0. Pop one -> exactly one new request follows. FIFO contents are unchanged and in order.
- 3 responses outstanding (3-cycle latency), redirect to 0x2003 -> next mem_addr=0x2000. The 3 stale responses are dropped. The first out_pc after the redirect is 0x2000.
- Redirect coincident with a response -> that response is dropped, drop is set to inflight-1, and no stale word ever reaches the output.
- priv_in toggled 0→1 between two grants -> out_priv=0 then 1 on the corresponding instructions, independent of priv_in at pop time.
- halt asserted mid-stream at fetch_pc=0x10 with 2 in flight -> both are delivered, no new requests. Release halt -> requests resume at 0x10. Also check fetch_pc=0xFFFF_FFFC wraps to 0x0000_0000.
